// File: rtl/vga_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_scan_gen : pixel-tick divider plus h/v raster counters with sync,      |
// |                video_on and frame_start decode for the renderers.          |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module vga_scan_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_scan_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_scan_gen: CLK_DIV must be in 1..16");
    end
  endgenerate

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so a 1024-wide visible area still compares correctly
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [3:0]  div_q, div_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [10:0] hc_ext, vc_ext;
  logic        h_last, v_last;

  assign hc_ext   = {1'b0, hcount_q};
  assign vc_ext   = {1'b0, vcount_q};
  assign h_last   = (hcount_q == H_LAST);
  assign v_last   = (vcount_q == V_LAST);
  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d    = pix_tick ? 4'd0 : div_q + 4'd1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_tick) begin
      if (h_last) begin
        hcount_d = 10'd0;
        vcount_d = v_last ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= 4'd0;
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // All decodes come from registered counters only, so they hold for the pixel.
  assign x           = hcount_q;
  assign y           = vcount_q;
  assign video_on    = (hc_ext < H_VIS) && (vc_ext < V_VIS);
  assign hsync       = ((hc_ext >= HS_BEG) && (hc_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = ((vc_ext >= VS_BEG) && (vc_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign frame_start = pix_tick && h_last && v_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_scan_gen : scoreboard bench for vga_scan_gen on a reduced raster.   |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_vga_scan_gen;

  // Small raster keeps several full frames well inside the cycle budget.
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 5, VF = 1, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int CDA = 2;
  localparam int CDB = 1;
  localparam bit POLA = 1'b0;
  localparam bit POLB = 1'b1;
  localparam int CLK_NS = 10;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
  } scan_t;

  typedef struct packed {
    scan_t a;
    scan_t b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] xa, ya, xb, yb;
  logic       ta, va, ha, vsa, fa;
  logic       tb, vb, hb, vsb, fb;
  scan_t      act_a, act_b;

  assign act_a = {xa, ya, ta, va, ha, vsa, fa};
  assign act_b = {xb, yb, tb, vb, hb, vsb, fb};

  always #(CLK_NS / 2) clk = ~clk;

  vga_scan_gen #(
    .CLK_DIV(CDA), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POLA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .x(xa), .y(ya), .pix_tick(ta), .video_on(va),
    .hsync(ha), .vsync(vsa), .frame_start(fa)
  );

  vga_scan_gen #(
    .CLK_DIV(CDB), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POLB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .x(xb), .y(yb), .pix_tick(tb), .video_on(vb),
    .hsync(hb), .vsync(vsb), .frame_start(fb)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fs   = 0;
  int got_fs   = 0;
  pair_t q[$];

  // t = clock edges seen since reset release; the raster position is just
  // the pixel index t/cd folded over the frame and the line.
  function automatic scan_t model(int t, int cd, bit pol);
    scan_t e;
    int p, pos, px, py;
    p    = t / cd;
    pos  = p % (HT * VT);
    px   = pos % HT;
    py   = pos / HT;
    e.x    = 10'(px);
    e.y    = 10'(py);
    e.tick = ((t % cd) == cd - 1);
    e.von  = (px < HV) && (py < VV);
    e.hs   = (px >= HV + HF && px < HV + HF + HS) ? pol : ~pol;
    e.vs   = (py >= VV + VF && py < VV + VF + VS) ? pol : ~pol;
    e.fs   = e.tick && (pos == HT * VT - 1);
    return e;
  endfunction

  task automatic check_scan(string name, scan_t got, scan_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got x=%0d y=%0d tick=%b von=%b hs=%b vs=%b fs=%b, expected x=%0d y=%0d tick=%b von=%b hs=%b vs=%b fs=%b",
                  name, $time, got.x, got.y, got.tick, got.von, got.hs, got.vs, got.fs,
                  exp.x, exp.y, exp.tick, exp.von, exp.hs, exp.vs, exp.fs);
  endtask

  task automatic check_int(string name, longint got, longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
  endtask

  // Reference model: one expected pair per clock edge.
  initial begin
    int t;
    pair_t e;
    t = 0;
    forever begin
      @(posedge clk);
      if (rst_n) t++;
      else t = 0;
      #1;
      e.a = model(t, CDA, POLA);
      e.b = model(t, CDB, POLB);
      if (e.a.fs) exp_fs++;
      q.push_back(e);
    end
  end

  // Monitor: pops one expectation per pixel-clock period, away from the edge.
  initial begin
    pair_t e;
    time   last_fs;
    bit    have_fs;
    have_fs = 1'b0;
    last_fs = 0;
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        check_int("queue_empty", 0, 1);
      end else begin
        e = q.pop_front();
        check_scan("scan_a", act_a, e.a);
        check_scan("scan_b", act_b, e.b);
      end
      if (!rst_n) begin
        have_fs = 1'b0;
      end else if (fa) begin
        got_fs++;
        if (have_fs) check_int("fs_spacing", longint'($time - last_fs), longint'(HT * VT * CDA * CLK_NS));
        have_fs = 1'b1;
        last_fs = $time;
      end
    end
  end

  // Asserts reset between edges and checks the outputs collapse before any edge.
  task automatic pulse_reset(int hold);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_scan("async_rst_a", act_a, model(0, CDA, POLA));
    check_scan("async_rst_b", act_b, model(0, CDB, POLB));
    repeat (hold) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;
    // Three frames of dut_a plus margin.
    repeat (3 * HT * VT * CDA + 40) @(negedge clk);
    // Fresh start, then reset at a fixed mid-frame pixel (x=5, y=3).
    pulse_reset(3);
    repeat ((3 * HT + 5) * CDA) @(negedge clk);
    pulse_reset(4);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(20, 400)) @(negedge clk);
      pulse_reset($urandom_range(2, 6));
    end
    repeat (3 * HT * VT * CDA + 20) @(negedge clk);
    #1;
    check_int("fs_count", got_fs, exp_fs);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster scan generator that produces the pixel coordinates and sync timing consumed by the glyph and sprite renderers.
- Each renderer takes x, y and an enable, and returns a disp bit. This block is the producer side of that x/y interface.
- Divides the board clock down to a pixel tick and walks a horizontal/vertical counter pair through the full 640x480@60 frame, including blanking.
- Drives x, y, video_on, hsync and vsync to the renderers and the VGA pins, and emits a frame_start pulse for game-logic updates.

Parameters:
- CLK_DIV, 4, board clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- x  output  10  current horizontal count (hcount), 0..H_TOTAL-1.
- y  output  10  current vertical count (vcount), 0..V_TOTAL-1.
- pix_tick  output  1  one-clk strobe, once per CLK_DIV clocks; counters advance on it.
- video_on  output  1  high when (x, y) is inside the visible area.
- hsync  output  1  horizontal sync, polarity per SYNC_POL.
- vsync  output  1  vertical sync, polarity per SYNC_POL.
- frame_start  output  1  one-clk pulse on the last pixel of the frame.

Behaviour:
- One clock domain. Reset is asynchronous on rst_n low, active-low, released synchronously to clk by the board reset logic.
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525). Both must be at most 1024; elaboration is an error otherwise.
- State: div counter (4 bits), hcount (10 bits), vcount (10 bits), all registered. No other state.
- div counts 0..CLK_DIV-1 and wraps to 0.
  - pix_tick = (div == CLK_DIV-1), decoded from the registered div.
  - CLK_DIV=1 gives pix_tick constantly high.
- On a clk edge with pix_tick high:
  - if hcount == H_TOTAL-1: hcount <= 0, and vcount <= (vcount == V_TOTAL-1) ? 0 : vcount+1;
  - else hcount <= hcount+1.
- Counters hold when pix_tick is low. No other wrap paths: hcount never exceeds H_TOTAL-1 and vcount never exceeds V_TOTAL-1.
- x = hcount and y = vcount at all times, including blanking. Renderers AND their disp with video_on.
- video_on = (hcount < H_VISIBLE) && (vcount < V_VISIBLE).
- hsync is active (level SYNC_POL) when H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751 at defaults. It is inactive otherwise.
- vsync is active when V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. lines 490..491. It is inactive otherwise.
- video_on, hsync, vsync and frame_start are decoded from registered state only, with no combinational input paths. They are stable for the whole pixel period.
- frame_start = pix_tick && hcount == H_TOTAL-1 && vcount == V_TOTAL-1. It is high for exactly one clk per frame, coincident with the tick that wraps to (0,0).
- Reset values (defaults): div=0, x=0, y=0, pix_tick=0 (1 if CLK_DIV=1), video_on=1, hsync=1, vsync=1, frame_start=0.
- Reset mid-frame returns immediately to the reset values. The scan restarts at (0,0) with a full CLK_DIV wait before the first advance. No partial sync pulse is extended.
- Frame period at defaults: 800*525*4 = 1,680,000 clks.

Test Plan:
- Reset: hold rst_n low 10 clks -> x=0, y=0, hsync=1, vsync=1, video_on=1, pix_tick=0. Release -> first pix_tick on clk 4, then every 4 clks; x=1 after the first tick.
- Line timing: run one line -> hsync low exactly while x = 656..751 (96 ticks, 384 clks). video_on falls when x goes 639 -> 640. At x=799 the tick wraps x to 0 and increments y 0 -> 1.
- Frame timing: run one full frame -> vsync low for all of lines y=490 and 491 (1600 ticks). video_on stays low for y >= 480. Wrap is at (799,524) -> (0,0).
- frame_start: over 3 frames -> exactly 3 one-clk pulses, spaced 1,680,000 clks apart, each coincident with pix_tick at (799,524).
- Mid-frame reset: assert rst_n at (300,200) during a pixel period -> outputs return to reset values asynchronously, without waiting for a clk edge. After release, the counters restart at (0,0).
- CLK_DIV=1 build: pix_tick constantly 1 after reset. x advances every clk and the line period is 800 clks.
